// File: rtl/param_sequence_detector_pkg.sv
// Shared types and defaults for the parametrised sequence detector.
// Optional SEQ_DET_MASK_EN adds a per-bit pattern mask.
package seq_det_pkg;

  typedef enum logic {
    FILL,
    ARMED
  } state_e;

  localparam int PATTERN_W_DEF = 4;
  localparam int CNT_W_DEF = 8;
  localparam logic [3:0] RST_PATTERN_DEF = 4'b1011;

  // Fill counter holds 0..pw-1.
  function automatic int fill_w(input int pw);
    return $clog2(pw);
  endfunction

endpackage

// File: rtl/param_sequence_detector_if.sv
// Stream, config and result bundle of the sequence detector.
// Optional SEQ_DET_MASK_EN adds pattern_mask_in.
interface param_sequence_detector_if #(
  parameter int PATTERN_W = 4,
  parameter int CNT_W = 8
);
  logic in;
  logic in_valid;
  logic cfg_load;
  logic [PATTERN_W-1:0] pattern_in;
`ifdef SEQ_DET_MASK_EN
  logic [PATTERN_W-1:0] pattern_mask_in;
`endif
  logic overlap_en;
  logic count_clr;
  logic out;
  logic [CNT_W-1:0] match_count;
  logic state_armed;

`ifdef SEQ_DET_MASK_EN
  modport master (
    output in, in_valid, cfg_load,
    output pattern_in, pattern_mask_in,
    output overlap_en, count_clr,
    input out, match_count, state_armed
  );
  modport slave (
    input in, in_valid, cfg_load,
    input pattern_in, pattern_mask_in,
    input overlap_en, count_clr,
    output out, match_count, state_armed
  );
`else
  modport master (
    output in, in_valid, cfg_load,
    output pattern_in,
    output overlap_en, count_clr,
    input out, match_count, state_armed
  );
  modport slave (
    input in, in_valid, cfg_load,
    input pattern_in,
    input overlap_en, count_clr,
    output out, match_count, state_armed
  );
`endif
endinterface

// File: rtl/param_sequence_detector_sat_counter.sv
// Saturating up-counter with clear priority over increment.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);
  logic [W-1:0] count_q, count_d;

  // Clear wins; increment holds at all-ones.
  always_comb begin
    count_d = count_q;
    if (clr) count_d = '0;
    else if (inc && count_q != '1)
      count_d = count_q + W'(1);
  end

  // Count register, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) count_q <= '0;
    else count_q <= count_d;
  end

  assign count = count_q;
endmodule

// File: rtl/param_sequence_detector.sv
// Runtime-loadable serial pattern detector, overlap selectable.
// Optional SEQ_DET_MASK_EN makes masked pattern bits don't-care.
module param_sequence_detector
  import seq_det_pkg::*;
#(
  parameter int PATTERN_W = PATTERN_W_DEF,
  parameter int CNT_W = CNT_W_DEF,
  parameter logic [PATTERN_W-1:0] RST_PATTERN = RST_PATTERN_DEF
) (
  input logic clk,
  input logic reset,
  param_sequence_detector_if.slave bus
);
  localparam int HW = PATTERN_W - 1;
  localparam int FW = fill_w(PATTERN_W);
  localparam logic [FW-1:0] FILL_MAX = FW'(HW);

  state_e state_q, state_d;
  logic [HW-1:0] hist_q, hist_d;
  logic [FW-1:0] fill_q, fill_d;
  logic [PATTERN_W-1:0] pat_q, pat_d;
  logic [PATTERN_W-1:0] word;
  logic out_q, out_d;
  logic match, hit;

`ifdef SEQ_DET_MASK_EN
  logic [PATTERN_W-1:0] mask_q, mask_d;
  assign match = ((word ^ pat_q) & mask_q) == '0;
`else
  assign match = word == pat_q;
`endif

  assign word = {hist_q, bus.in};

  // Next state: load beats stream; match only counted when armed.
  always_comb begin
    state_d = state_q;
    hist_d = hist_q;
    fill_d = fill_q;
    pat_d = pat_q;
`ifdef SEQ_DET_MASK_EN
    mask_d = mask_q;
`endif
    out_d = 1'b0;
    hit = 1'b0;
    if (bus.cfg_load) begin
      pat_d = bus.pattern_in;
`ifdef SEQ_DET_MASK_EN
      mask_d = bus.pattern_mask_in;
`endif
      hist_d = '0;
      fill_d = '0;
      state_d = FILL;
    end else if (bus.in_valid) begin
      unique case (state_q)
        FILL: begin
          hist_d = word[HW-1:0];
          fill_d = fill_q + FW'(1);
          if (fill_d == FILL_MAX) state_d = ARMED;
        end
        ARMED: begin
          hist_d = word[HW-1:0];
          if (match) begin
            out_d = 1'b1;
            hit = 1'b1;
            if (!bus.overlap_en) begin
              hist_d = '0;
              fill_d = '0;
              state_d = FILL;
            end
          end
        end
        default: state_d = FILL;
      endcase
    end
  end

  // State, history, pattern and pulse registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= FILL;
      hist_q <= '0;
      fill_q <= '0;
      pat_q <= RST_PATTERN;
`ifdef SEQ_DET_MASK_EN
      mask_q <= '1;
`endif
      out_q <= 1'b0;
    end else begin
      state_q <= state_d;
      hist_q <= hist_d;
      fill_q <= fill_d;
      pat_q <= pat_d;
`ifdef SEQ_DET_MASK_EN
      mask_q <= mask_d;
`endif
      out_q <= out_d;
    end
  end

  sat_counter #(.W(CNT_W)) u_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (bus.count_clr),
    .inc   (hit),
    .count (bus.match_count)
  );

  assign bus.out = out_q;
  assign bus.state_armed = (state_q == ARMED);
endmodule
